// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : RV32I ALU issue stage. Decodes an R-type, I-type ALU, LUI or
//                AUIPC instruction into ALU operands and operation select, and
//                presents the result through a single ready/valid output
//                register. Unsupported encodings are still handshaked, but are
//                flagged illegal with zeroed operands, and counted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   rising-edge clock
//    rst_n         in   1   asynchronous active-low reset
//    in_valid      in   1   instr/pc/rs1_data/rs2_data valid
//    in_ready      out  1   input accepted this cycle
//    instr         in   32  RV32I instruction word
//    pc            in   32  address of instr
//    rs1_data      in   32  register value of instr[19:15]
//    rs2_data      in   32  register value of instr[24:20]
//    out_valid     out  1   registered ALU operation valid
//    out_ready     in   1   downstream consumes the operation
//    A, B          out  32  ALU operands
//    funct3        out  3   ALU operation select
//    funct7        out  7   ALU operation modifier (SUB / SRA)
//    rd            out  5   destination register
//    reg_we        out  1   writeback enable
//    illegal       out  1   operation is not a supported ALU instruction
//    illegal_count out  8   saturating count of accepted illegal instructions
// ============================================================================
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        illegal,
    output logic [7:0]  illegal_count
);

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_F7_ZERO  = 7'b0000000;
    localparam logic [6:0] c_F7_ALT   = 7'b0100000;
    localparam logic [7:0] c_CNT_MAX  = 8'hFF;

    // ------------------------------------------------------------------
    // Instruction decode (purely combinational from the input bus)
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_instr_f3;
    logic [6:0]  w_instr_f7;
    logic        w_dec_legal;
    logic [31:0] w_dec_a;
    logic [31:0] w_dec_b;
    logic [2:0]  w_dec_f3;
    logic [6:0]  w_dec_f7;

    assign w_opcode   = instr[6:0];
    assign w_instr_f3 = instr[14:12];
    assign w_instr_f7 = instr[31:25];

    always_comb begin
        w_dec_legal = 1'b0;
        w_dec_a     = 32'd0;
        w_dec_b     = 32'd0;
        w_dec_f3    = 3'b000;
        w_dec_f7    = c_F7_ZERO;

        case (w_opcode)
            c_OP_R: begin
                w_dec_legal = (w_instr_f7 == c_F7_ZERO) ||
                              ((w_instr_f7 == c_F7_ALT) &&
                               ((w_instr_f3 == 3'b000) || (w_instr_f3 == 3'b101)));
                w_dec_a     = rs1_data;
                w_dec_b     = rs2_data;
                w_dec_f3    = w_instr_f3;
                w_dec_f7    = w_instr_f7;
            end
            c_OP_IMM: begin
                w_dec_a  = rs1_data;
                w_dec_f3 = w_instr_f3;
                case (w_instr_f3)
                    3'b001: begin
                        // SLLI: upper immediate bits must be zero
                        w_dec_legal = (w_instr_f7 == c_F7_ZERO);
                        w_dec_b     = {27'd0, instr[24:20]};
                    end
                    3'b101: begin
                        // SRLI/SRAI: instr[30] selects arithmetic shift
                        w_dec_legal = (w_instr_f7 == c_F7_ZERO) ||
                                      (w_instr_f7 == c_F7_ALT);
                        w_dec_b     = {27'd0, instr[24:20]};
                        w_dec_f7    = w_instr_f7;
                    end
                    default: begin
                        w_dec_legal = 1'b1;
                        w_dec_b     = {{20{instr[31]}}, instr[31:20]};
                    end
                endcase
            end
            c_OP_LUI: begin
                w_dec_legal = 1'b1;
                w_dec_b     = {instr[31:12], 12'd0};
            end
            c_OP_AUIPC: begin
                w_dec_legal = 1'b1;
                w_dec_a     = pc;
                w_dec_b     = {instr[31:12], 12'd0};
            end
            default: begin
                w_dec_legal = 1'b0;
            end
        endcase

        // Illegal operations present a neutral all-zero operation
        if (!w_dec_legal) begin
            w_dec_a  = 32'd0;
            w_dec_b  = 32'd0;
            w_dec_f3 = 3'b000;
            w_dec_f7 = c_F7_ZERO;
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic        r_valid_q,   w_valid_d;
    logic [31:0] r_a_q,       w_a_d;
    logic [31:0] r_b_q,       w_b_d;
    logic [2:0]  r_f3_q,      w_f3_d;
    logic [6:0]  r_f7_q,      w_f7_d;
    logic [4:0]  r_rd_q,      w_rd_d;
    logic        r_we_q,      w_we_d;
    logic        r_illegal_q, w_illegal_d;
    logic [7:0]  r_cnt_q,     w_cnt_d;
    logic        w_accept;

    // A consume and an accept in the same cycle reload the register directly
    assign in_ready = !r_valid_q || out_ready;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_valid_d   = r_valid_q;
        w_a_d       = r_a_q;
        w_b_d       = r_b_q;
        w_f3_d      = r_f3_q;
        w_f7_d      = r_f7_q;
        w_rd_d      = r_rd_q;
        w_we_d      = r_we_q;
        w_illegal_d = r_illegal_q;
        w_cnt_d     = r_cnt_q;

        if (w_accept) begin
            w_valid_d   = 1'b1;
            w_a_d       = w_dec_a;
            w_b_d       = w_dec_b;
            w_f3_d      = w_dec_f3;
            w_f7_d      = w_dec_f7;
            w_rd_d      = instr[11:7];
            w_we_d      = w_dec_legal && (instr[11:7] != 5'd0);
            w_illegal_d = !w_dec_legal;
            if (!w_dec_legal && (r_cnt_q != c_CNT_MAX)) begin
                w_cnt_d = r_cnt_q + 8'd1;
            end
        end else if (out_ready) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q   <= 1'b0;
            r_a_q       <= 32'd0;
            r_b_q       <= 32'd0;
            r_f3_q      <= 3'b000;
            r_f7_q      <= c_F7_ZERO;
            r_rd_q      <= 5'd0;
            r_we_q      <= 1'b0;
            r_illegal_q <= 1'b0;
            r_cnt_q     <= 8'd0;
        end else begin
            r_valid_q   <= w_valid_d;
            r_a_q       <= w_a_d;
            r_b_q       <= w_b_d;
            r_f3_q      <= w_f3_d;
            r_f7_q      <= w_f7_d;
            r_rd_q      <= w_rd_d;
            r_we_q      <= w_we_d;
            r_illegal_q <= w_illegal_d;
            r_cnt_q     <= w_cnt_d;
        end
    end

    assign out_valid     = r_valid_q;
    assign A             = r_a_q;
    assign B             = r_b_q;
    assign funct3        = r_f3_q;
    assign funct7        = r_f7_q;
    assign rd            = r_rd_q;
    assign reg_we        = r_we_q;
    assign illegal       = r_illegal_q;
    assign illegal_count = r_cnt_q;

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the single clock; rst_n is the asynchronous, active-low reset.
REQ-002 The block SHALL have no parameters; all widths are fixed at RV32I values.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  instr/pc/rs1_data/rs2_data valid this cycle.
REQ-006 in_ready  out  1  block accepts the input this cycle.
REQ-007 instr  in  32  RV32I instruction word.
REQ-008 pc  in  32  address of instr.
REQ-009 rs1_data  in  32  register-file value of instr[19:15].
REQ-010 rs2_data  in  32  register-file value of instr[24:20].
REQ-011 out_valid  out  1  registered ALU operation valid.
REQ-012 out_ready  in  1  ALU/downstream consumes the operation.
REQ-013 A, B  out  32 each  ALU operands.
REQ-014 funct3  out  3, funct7  out  7  ALU operation select; the ALU decodes 000/0100000 as SUB and 101/0100000 as SRA, with funct7=0000000 for all other operations.
REQ-015 rd  out  5  destination register; reg_we  out  1  writeback enable.
REQ-016 illegal  out  1  registered operation is not a supported ALU instruction.
REQ-017 illegal_count  out  8  saturating count of accepted illegal instructions.

Function
REQ-018 One output register stage SHALL be used: in_ready = !out_valid || out_ready; the input is accepted when in_valid && in_ready.
REQ-019 Accept in cycle N SHALL give out_valid=1 with the decoded fields in cycle N+1.
REQ-020 out_valid SHALL clear on out_ready && !accept. Simultaneous consume and accept SHALL reload the register with no bubble.
REQ-021 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-022 R-type (opcode 0110011): A=rs1_data, B=rs2_data, funct3=instr[14:12], funct7=instr[31:25]. The instruction is legal only if funct7=0000000, or funct7=0100000 with funct3 in {000,101}.
REQ-023 I-type ALU (opcode 0010011), funct3 in {000,010,011,100,110,111}: A=rs1_data, B=sign-extended instr[31:20], funct7 forced to 0000000.
REQ-024 I-type ALU, funct3=001 (SLLI): B={27'b0,instr[24:20]}; legal only if instr[31:25]=0000000.
REQ-025 I-type ALU, funct3=101 (SRLI/SRAI): B={27'b0,instr[24:20]}, funct7=instr[31:25]; legal only if instr[31:25] is 0000000 or 0100000.
REQ-026 LUI (0110111): A=0, B={instr[31:12],12'b0}, funct3=000, funct7=0000000.
REQ-027 AUIPC (0010111): A=pc, B={instr[31:12],12'b0}, funct3=000, funct7=0000000.
REQ-028 Any other opcode, or a rule violation, SHALL register illegal=1, reg_we=0, and A=B=0, funct3=000, funct7=0000000. The operation is still presented and handshaked.
REQ-029 rd=instr[11:7] SHALL be registered. reg_we = legal && rd!=0.
REQ-030 illegal_count SHALL increment by 1 on each accepted illegal instruction and saturate at 255, never wrapping.

Reset
REQ-031 rst_n low SHALL immediately force out_valid=0, A=B=0, funct3=000, funct7=0000000, rd=0, reg_we=0, illegal=0, illegal_count=0, independent of clk.
REQ-032 Reset mid-operation SHALL discard any held operation. in_ready SHALL read 1 during reset and on the first cycle after release.

Verification
REQ-033 instr=0x002081B3 (ADD x3,x1,x2), rs1_data=5, rs2_data=3, out_ready=1 -> next cycle: out_valid=1, A=5, B=3, funct3=000, funct7=0000000, rd=3, reg_we=1, illegal=0.
REQ-034 instr=0x402081B3 (SUB) -> funct7=0100000. instr=0xFFF00293 (ADDI x5,x0,-1) with rs1_data=0 -> A=0, B=0xFFFFFFFF, funct7=0000000, rd=5.
REQ-035 instr=0x4040D313 (SRAI x6,x1,4) -> B=4, funct3=101, funct7=0100000. instr=0x123453B7 (LUI x7) -> A=0, B=0x12345000, rd=7.
REQ-036 Backpressure: out_valid=1 and out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and outputs unchanged. When out_ready rises with in_valid=1 -> the new operation appears the next cycle with no bubble.
REQ-037 Illegal: 300 accepted instr=0xFFFFFFFF -> illegal=1, reg_we=0 each time, illegal_count=255 at the end. Pulse rst_n low mid-stream -> out_valid=0 and illegal_count=0 immediately.
